// File: rtl/key_event_queue.sv
// key_event_queue: decodes PS/2 scan bytes into {ext, brk, code} events,
// optionally filters typematic repeats, and buffers them in a fall-through FIFO.
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 keycode,
    input  logic                       keypress,
    input  logic                       rd_en,
    input  logic                       clr_ovf,
    output logic [9:0]                 ev_data,
    output logic                       ev_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state, state_nxt;
    logic            is_e0, is_f0, brk_st, ev_done, ev_ext, match, push, pop, full, wr;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [8:0]      lm_key;
    logic            lm_valid;
    logic [9:0]      mem [DEPTH];

    always_comb begin
        is_e0     = keycode == 8'hE0;
        is_f0     = keycode == 8'hF0;
        brk_st    = state == BRK || state == EXT_BRK;
        ev_ext    = state == EXT || state == EXT_BRK;
        state_nxt = state;
        ev_done   = 1'b0;
        if (keypress) begin
            if (brk_st && (is_e0 || is_f0)) state_nxt = IDLE;
            else if (state == IDLE && is_e0) state_nxt = EXT;
            else if (state == IDLE && is_f0) state_nxt = BRK;
            else if (state == EXT && is_f0) state_nxt = EXT_BRK;
            else begin
                state_nxt = IDLE;
                ev_done   = 1'b1;
            end
        end
    end

    // A repeated make of the last held key is a typematic repeat and is dropped
    assign match = lm_valid && lm_key == {ev_ext, keycode};
    assign push  = ev_done && !(FILTER_REPEAT != 0 && !brk_st && match);
    assign full  = count == FULL;
    assign pop   = rd_en && ev_valid;
    assign wr    = push && (!full || pop);

    assign ev_valid = count != '0;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            lm_key   <= '0;
            lm_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
            if (push && full && !pop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (FILTER_REPEAT != 0 && ev_done) begin
                if (brk_st) begin
                    if (match) lm_valid <= 1'b0;
                end else if (!match) begin
                    lm_key   <= {ev_ext, keycode};
                    lm_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {ev_ext, brk_st, keycode};
    end
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed scenario tests for key_event_queue (DEPTH=8, FILTER_REPEAT=1).
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keycode = '0;
    logic       keypress = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic [3:0] count;
    logic       overflow;
    int         checks = 0;
    int         failures = 0;

    key_event_queue #(.DEPTH(8), .FILTER_REPEAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .keycode(keycode), .keypress(keypress),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_data(ev_data), .ev_valid(ev_valid),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        keycode  = b;
        keypress = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
    endtask

    task automatic pop;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [9:0] d, input logic [3:0] c);
        checks++;
        if (ev_data !== d || count !== c) begin
            failures++;
            $display("FAIL %s: ev_data=%h count=%0d, required ev_data=%h count=%0d", name, ev_data, count, d, c);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({ev_valid, ev_data, count, overflow} !== 16'h0) begin
            failures++;
            $display("FAIL reset: valid=%b data=%h count=%0d ovf=%b, required all zero", ev_valid, ev_data, count, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_make_break;
        @(negedge clk);
        keycode  = 8'h1C;
        keypress = 1'b1;
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_pre: ev_valid=%b, required 0", ev_valid);
        end
        @(negedge clk);
        keypress = 1'b0;
        checks++;
        if (ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_post: ev_valid=%b, required 1", ev_valid);
        end
        send(8'hF0);
        send(8'h1C);
        expect_head("make_break_head", 10'h01C, 4'd2);
        pop();
        expect_head("make_break_second", 10'h11C, 4'd1);
        pop();
        expect_head("make_break_empty", 10'h000, 4'd0);
    endtask

    task automatic test_extended;
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_head("ext_make", 10'h275, 4'd2);
        pop();
        expect_head("ext_break", 10'h375, 4'd1);
        pop();
    endtask

    task automatic test_repeat_filter;
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        expect_head("repeat_first", 10'h01C, 4'd3);
        pop();
        expect_head("repeat_break", 10'h11C, 4'd2);
        pop();
        expect_head("repeat_remake", 10'h01C, 4'd1);
        pop();
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        expect_head("full_head", 10'h015, 4'd8);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: overflow=%b, required 1", overflow);
        end
        @(negedge clk);
        keycode  = 8'h1F;
        keypress = 1'b1;
        clr_ovf  = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
        clr_ovf  = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL clr_vs_drop: overflow=%b count=%0d, required 1 and 8", overflow, count);
        end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_q [8] = '{10'h016, 10'h017, 10'h018, 10'h019, 10'h01A, 10'h01B, 10'h01C, 10'h01E};
        @(negedge clk);
        keycode  = 8'h1E;
        keypress = 1'b1;
        rd_en    = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
        rd_en    = 1'b0;
        expect_head("full_push_pop", 10'h016, 4'd8);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop_ovf: overflow=%b, required 0", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            expect_head("drain", exp_q[i], 4'(8 - i));
            pop();
        end
        pop();
        expect_head("pop_empty", 10'h000, 4'd0);
        @(negedge clk);
        keycode  = 8'h20;
        keypress = 1'b1;
        rd_en    = 1'b1;
        @(negedge clk);
        keypress = 1'b0;
        rd_en    = 1'b0;
        expect_head("empty_push_pop", 10'h020, 4'd1);
        pop();
    endtask

    task automatic test_protocol_error;
        send(8'hF0); send(8'hE0); send(8'h22);
        expect_head("proto_error", 10'h022, 4'd1);
        send(8'hF0); send(8'hF0); send(8'h2A);
        expect_head("proto_error_ff", 10'h022, 4'd2);
        pop();
        expect_head("proto_error_next", 10'h02A, 4'd1);
    endtask

    task automatic test_async_reset;
        send(8'hE0);
        send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ev_valid, ev_data, count, overflow} !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%h count=%0d ovf=%b, required all zero", ev_valid, ev_data, count, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h75);
        expect_head("post_reset_event", 10'h075, 4'd1);
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat_filter();
        test_overflow();
        test_back_to_back();
        test_protocol_error();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
